// File: rtl/gsm_resp_pkg.sv
// Shared constants for the GSM modem response parser: result codes,
// line-control characters and the result strings matched by position.
package gsm_resp_pkg;

  localparam logic [2:0] RESP_NONE    = 3'd0;
  localparam logic [2:0] RESP_OK      = 3'd1;
  localparam logic [2:0] RESP_ERROR   = 3'd2;
  localparam logic [2:0] RESP_PROMPT  = 3'd3;
  localparam logic [2:0] RESP_TIMEOUT = 3'd4;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] GT = 8'h3E;
  localparam logic [7:0] SP = 8'h20;

  localparam int unsigned OK_LEN  = 2;
  localparam int unsigned ERR_LEN = 5;

  // Index 0 holds the first character of each string.
  localparam logic [0:1][7:0] MATCH_OK  = "OK";
  localparam logic [0:4][7:0] MATCH_ERR = "ERROR";

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } rpt_state_e;

  function automatic logic [7:0] ok_char(input int unsigned idx);
    case (idx)
      0:       ok_char = MATCH_OK[0];
      1:       ok_char = MATCH_OK[1];
      default: ok_char = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] err_char(input int unsigned idx);
    case (idx)
      0:       err_char = MATCH_ERR[0];
      1:       err_char = MATCH_ERR[1];
      2:       err_char = MATCH_ERR[2];
      3:       err_char = MATCH_ERR[3];
      4:       err_char = MATCH_ERR[4];
      default: err_char = 8'h00;
    endcase
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    is_term = (b == CR) || (b == LF);
  endfunction

endpackage

// File: rtl/gsm_resp_timer.sv
// Response timeout: down-counter loaded on start, single-cycle expired pulse
// in the cycle CYCLES-1 after start so the registered report lands at CYCLES.
module gsm_resp_timer #(
  parameter int unsigned CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  always_comb begin
    cnt_d   = cnt_q;
    run_d   = run_q;
    expired = run_q && enable && (cnt_q == CNT_W'(1));
    if (start) begin
      cnt_d = LOAD;
      run_d = 1'b1;
    end else if (stop || expired) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (run_q && enable) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/gsm_resp_parser.sv
// Modem response parser: assembles lines from uart_rx bytes, recognises
// "OK", "ERROR" and the "> " prompt, and reports them or a timeout while armed.
//
// state  | meaning
// S_IDLE | no command outstanding; results are discarded
// S_WAIT | command outstanding; first result or timeout is reported
module gsm_resp_parser
  import gsm_resp_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned TIMEOUT_MS = 5000,
  parameter int unsigned MAX_LINE   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       arm,
  output logic       waiting,
  output logic       resp_ok,
  output logic       resp_error,
  output logic       resp_prompt,
  output logic       resp_timeout,
  output logic [2:0] resp_code,
  output logic       line_overflow
);

  localparam int unsigned TIMEOUT_CYCLES = (CLK_FREQ / 1000) * TIMEOUT_MS;
  localparam int unsigned LEN_W          = $clog2(MAX_LINE + 1);

  rpt_state_e state_q, state_d;

  logic [LEN_W-1:0] len_q, len_d;
  logic             ok_pfx_q, ok_pfx_d;
  logic             err_pfx_q, err_pfx_d;
  logic             gt_pfx_q, gt_pfx_d;
  logic             ovf_q, ovf_d;

  logic       resp_ok_q, resp_ok_d;
  logic       resp_error_q, resp_error_d;
  logic       resp_prompt_q, resp_prompt_d;
  logic       resp_timeout_q, resp_timeout_d;
  logic [2:0] resp_code_q, resp_code_d;
  logic       line_overflow_q, line_overflow_d;

  int unsigned len_i;
  logic [2:0]  line_res;
  logic        ovf_pulse;
  logic        line_clr;
  logic        tmr_stop;
  logic        tmr_expired;

  assign len_i = 32'(len_q);

  // Prefix flags stay set while every byte so far matches the string at its position.
  always_comb begin
    len_d     = len_q;
    ok_pfx_d  = ok_pfx_q;
    err_pfx_d = err_pfx_q;
    gt_pfx_d  = gt_pfx_q;
    ovf_d     = ovf_q;
    line_res  = RESP_NONE;
    ovf_pulse = 1'b0;
    line_clr  = 1'b0;
    if (rx_valid) begin
      if (is_term(rx_data)) begin
        if (!ovf_q && ok_pfx_q && (len_i == OK_LEN)) begin
          line_res = RESP_OK;
        end else if (!ovf_q && err_pfx_q && (len_i == ERR_LEN)) begin
          line_res = RESP_ERROR;
        end
        line_clr = 1'b1;
      end else if (!ovf_q) begin
        if (len_i == MAX_LINE) begin
          ovf_d     = 1'b1;
          ovf_pulse = 1'b1;
        end else if (gt_pfx_q && (len_i == 1) && (rx_data == SP)) begin
          line_res = RESP_PROMPT;
          line_clr = 1'b1;
        end else begin
          ok_pfx_d  = ok_pfx_q && (len_i < OK_LEN) && (rx_data == ok_char(len_i));
          err_pfx_d = err_pfx_q && (len_i < ERR_LEN) && (rx_data == err_char(len_i));
          gt_pfx_d  = (len_i == 0) && (rx_data == GT);
          len_d     = len_q + LEN_W'(1);
        end
      end
    end
    if (line_clr) begin
      len_d     = '0;
      ok_pfx_d  = 1'b1;
      err_pfx_d = 1'b1;
      gt_pfx_d  = 1'b0;
      ovf_d     = 1'b0;
    end
  end

  // A line result outranks expiry; a fresh arm suppresses expiry of the old command.
  always_comb begin
    state_d         = state_q;
    resp_ok_d       = 1'b0;
    resp_error_d    = 1'b0;
    resp_prompt_d   = 1'b0;
    resp_timeout_d  = 1'b0;
    resp_code_d     = resp_code_q;
    line_overflow_d = ovf_pulse;
    tmr_stop        = 1'b0;
    if (state_q == S_WAIT) begin
      if (line_res != RESP_NONE) begin
        resp_code_d = line_res;
        state_d     = S_IDLE;
        tmr_stop    = 1'b1;
        case (line_res)
          RESP_OK:     resp_ok_d     = 1'b1;
          RESP_ERROR:  resp_error_d  = 1'b1;
          RESP_PROMPT: resp_prompt_d = 1'b1;
          default:     resp_ok_d     = 1'b0;
        endcase
      end else if (tmr_expired && !arm) begin
        resp_timeout_d = 1'b1;
        resp_code_d    = RESP_TIMEOUT;
        state_d        = S_IDLE;
        tmr_stop       = 1'b1;
      end
    end
    if (arm) begin
      state_d = S_WAIT;
    end
  end

  gsm_resp_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (arm),
    .stop    (tmr_stop),
    .enable  (state_q == S_WAIT),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      len_q           <= '0;
      ok_pfx_q        <= 1'b1;
      err_pfx_q       <= 1'b1;
      gt_pfx_q        <= 1'b0;
      ovf_q           <= 1'b0;
      resp_ok_q       <= 1'b0;
      resp_error_q    <= 1'b0;
      resp_prompt_q   <= 1'b0;
      resp_timeout_q  <= 1'b0;
      resp_code_q     <= RESP_NONE;
      line_overflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      ok_pfx_q        <= ok_pfx_d;
      err_pfx_q       <= err_pfx_d;
      gt_pfx_q        <= gt_pfx_d;
      ovf_q           <= ovf_d;
      resp_ok_q       <= resp_ok_d;
      resp_error_q    <= resp_error_d;
      resp_prompt_q   <= resp_prompt_d;
      resp_timeout_q  <= resp_timeout_d;
      resp_code_q     <= resp_code_d;
      line_overflow_q <= line_overflow_d;
    end
  end

  assign waiting       = (state_q == S_WAIT);
  assign resp_ok       = resp_ok_q;
  assign resp_error    = resp_error_q;
  assign resp_prompt   = resp_prompt_q;
  assign resp_timeout  = resp_timeout_q;
  assign resp_code     = resp_code_q;
  assign line_overflow = line_overflow_q;

endmodule

// File: tb/tb_gsm_resp_parser.sv
// Bench for gsm_resp_parser: two instances (32- and 4-character lines) share
// directed stimulus and are compared each cycle against a line/queue model.
module tb_gsm_resp_parser;

  localparam int TO_CYC = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       arm = 1'b0;

  logic [1:0] waiting_o, ok_o, err_o, prm_o, to_o, ovf_o;
  logic [2:0] code_o [2];

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  gsm_resp_parser #(.CLK_FREQ(1000), .TIMEOUT_MS(10), .MAX_LINE(32)) u0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .arm(arm),
    .waiting(waiting_o[0]), .resp_ok(ok_o[0]), .resp_error(err_o[0]),
    .resp_prompt(prm_o[0]), .resp_timeout(to_o[0]), .resp_code(code_o[0]),
    .line_overflow(ovf_o[0]));

  gsm_resp_parser #(.CLK_FREQ(1000), .TIMEOUT_MS(10), .MAX_LINE(4)) u1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .arm(arm),
    .waiting(waiting_o[1]), .resp_ok(ok_o[1]), .resp_error(err_o[1]),
    .resp_prompt(prm_o[1]), .resp_timeout(to_o[1]), .resp_code(code_o[1]),
    .line_overflow(ovf_o[1]));

  // Model state: the line as an array of received characters, elapsed edges since arm.
  int         ml [2] = '{32, 4};
  logic [7:0] m_buf [2][64];
  int         m_len [2];
  bit         m_ovf [2];
  bit         m_wait [2];
  int         m_age [2];
  logic [2:0] m_code [2];
  bit         m_ok [2], m_err [2], m_prm [2], m_to [2], m_ovfp [2];

  function automatic bit line_is(input int k, input string s);
    if (m_len[k] != s.len()) return 1'b0;
    for (int i = 0; i < s.len(); i++)
      if (m_buf[k][i] != s[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input int k);
    logic [2:0] res;
    res = 3'd0;
    m_ok[k] = 0; m_err[k] = 0; m_prm[k] = 0; m_to[k] = 0; m_ovfp[k] = 0;
    if (rst) begin
      m_wait[k] = 0; m_code[k] = 3'd0; m_len[k] = 0; m_ovf[k] = 0; m_age[k] = 0;
      return;
    end
    if (rx_valid) begin
      if (rx_data == 8'h0D || rx_data == 8'h0A) begin
        if (!m_ovf[k]) begin
          if (line_is(k, "OK")) res = 3'd1;
          else if (line_is(k, "ERROR")) res = 3'd2;
        end
        m_len[k] = 0;
        m_ovf[k] = 0;
      end else if (!m_ovf[k]) begin
        if (m_len[k] == ml[k]) begin
          m_ovf[k] = 1; m_ovfp[k] = 1;
        end else begin
          m_buf[k][m_len[k]] = rx_data;
          m_len[k]++;
          if (line_is(k, "> ")) begin res = 3'd3; m_len[k] = 0; end
        end
      end
    end
    if (m_wait[k]) begin
      m_age[k]++;
      if (res != 3'd0) begin
        m_code[k] = res; m_wait[k] = 0;
        if (res == 3'd1) m_ok[k] = 1;
        if (res == 3'd2) m_err[k] = 1;
        if (res == 3'd3) m_prm[k] = 1;
      end else if (!arm && m_age[k] == TO_CYC - 1) begin
        m_to[k] = 1; m_code[k] = 3'd4; m_wait[k] = 0;
      end
    end
    if (arm) begin m_wait[k] = 1; m_age[k] = 0; end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[u%0d] got=%0d want=%0d at %0t", name, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check("waiting", k, 32'(waiting_o[k]), 32'(m_wait[k]));
        check("resp_ok", k, 32'(ok_o[k]), 32'(m_ok[k]));
        check("resp_error", k, 32'(err_o[k]), 32'(m_err[k]));
        check("resp_prompt", k, 32'(prm_o[k]), 32'(m_prm[k]));
        check("resp_timeout", k, 32'(to_o[k]), 32'(m_to[k]));
        check("line_overflow", k, 32'(ovf_o[k]), 32'(m_ovfp[k]));
        check("resp_code", k, 32'(code_o[k]), 32'(m_code[k]));
      end
    end
  end

  task automatic step(input bit r, input bit a, input bit v, input logic [7:0] d);
    rst = r; arm = a; rx_valid = v; rx_data = d;
    @(posedge clk);
    #1;
    rst = 1'b0; arm = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(0, 0, 1, s[i]);
  endtask

  task automatic send_line(input string s);
    send(s);
    step(0, 0, 1, 8'h0D);
    step(0, 0, 1, 8'h0A);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    check("lit_reset_code", 0, 32'(code_o[0]), 32'd0);
    check("lit_reset_wait", 0, 32'(waiting_o[0]), 32'd0);

    // Basic OK with leading empty line
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h0D); step(0, 0, 1, 8'h0A);
    send("OK");
    step(0, 0, 1, 8'h0D);
    check("lit_ok_pulse", 0, 32'(ok_o[0]), 32'd1);
    check("lit_ok_code", 0, 32'(code_o[0]), 32'd1);
    check("lit_ok_wait", 0, 32'(waiting_o[0]), 32'd0);
    step(0, 0, 1, 8'h0A);
    check("lit_ok_lf", 0, 32'(ok_o[0]), 32'd0);

    // ERROR, then non-matching lines
    step(0, 1, 0, 8'h00);
    send("ERROR");
    step(0, 0, 1, 8'h0D);
    check("lit_err_pulse", 0, 32'(err_o[0]), 32'd1);
    check("lit_err_code", 0, 32'(code_o[0]), 32'd2);
    step(0, 0, 1, 8'h0A);
    step(0, 1, 0, 8'h00);
    send_line("ERRORS");
    step(0, 1, 0, 8'h00);
    send_line("ok");
    check("lit_nomatch_wait", 0, 32'(waiting_o[0]), 32'd1);
    check("lit_nomatch_code", 0, 32'(code_o[0]), 32'd2);
    idle(12);
    check("lit_after_to_code", 0, 32'(code_o[0]), 32'd4);

    // Prompt, then unarmed OK
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h3E);
    step(0, 0, 1, 8'h20);
    check("lit_prompt_pulse", 0, 32'(prm_o[0]), 32'd1);
    check("lit_prompt_code", 0, 32'(code_o[0]), 32'd3);
    send("OK");
    step(0, 0, 1, 8'h0D);
    check("lit_unarmed_ok", 0, 32'(ok_o[0]), 32'd0);
    check("lit_unarmed_code", 0, 32'(code_o[0]), 32'd3);
    step(0, 0, 1, 8'h0A);

    // Timeout after exactly TO_CYC cycles
    idle(2);
    step(0, 1, 0, 8'h00);
    idle(8);
    check("lit_to_early", 0, 32'(to_o[0]), 32'd0);
    idle(1);
    check("lit_to_pulse", 0, 32'(to_o[0]), 32'd1);
    check("lit_to_code", 0, 32'(code_o[0]), 32'd4);

    // OK decided in the expiry cycle wins
    step(0, 1, 0, 8'h00);
    idle(6);
    send("OK");
    step(0, 0, 1, 8'h0D);
    check("lit_race_ok", 0, 32'(ok_o[0]), 32'd1);
    check("lit_race_to", 0, 32'(to_o[0]), 32'd0);
    step(0, 0, 1, 8'h0A);

    // Re-arm while waiting restarts the count
    step(0, 1, 0, 8'h00);
    idle(5);
    step(0, 1, 0, 8'h00);
    idle(9);
    check("lit_rearm_to", 0, 32'(to_o[0]), 32'd1);

    // Arm together with a deciding CR
    step(0, 1, 0, 8'h00);
    send("OK");
    step(0, 1, 1, 8'h0D);
    check("lit_armres_ok", 0, 32'(ok_o[0]), 32'd1);
    check("lit_armres_wait", 0, 32'(waiting_o[0]), 32'd1);
    step(0, 0, 1, 8'h0A);
    idle(8);
    check("lit_armres_to", 0, 32'(to_o[0]), 32'd1);

    // Overflow on the 4-character instance
    step(0, 1, 0, 8'h00);
    send("ABCD");
    step(0, 0, 1, 8'h45);
    check("lit_ovf_u1", 1, 32'(ovf_o[1]), 32'd1);
    check("lit_ovf_u0", 0, 32'(ovf_o[0]), 32'd0);
    send("FOK");
    step(0, 0, 1, 8'h0D);
    check("lit_ovf_no_ok", 1, 32'(ok_o[1]), 32'd0);
    check("lit_ovf_to", 1, 32'(to_o[1]), 32'd1);
    step(0, 0, 1, 8'h0A);
    step(0, 1, 0, 8'h00);
    send("OK");
    step(0, 0, 1, 8'h0D);
    check("lit_ovf_then_ok", 1, 32'(ok_o[1]), 32'd1);
    step(0, 0, 1, 8'h0A);

    // Reset mid-line discards the partial line and the wait
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h4F);
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'h4B);
    step(0, 0, 1, 8'h0D);
    check("lit_rst_ok", 0, 32'(ok_o[0]), 32'd0);
    check("lit_rst_wait", 0, 32'(waiting_o[0]), 32'd0);
    check("lit_rst_code", 0, 32'(code_o[0]), 32'd0);
    idle(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/gsm_resp_parser.md
Name: gsm_resp_parser

Overview:
- Receive-side counterpart of the GSM alert transmit path. It consumes the byte stream returned by the GSM modem from a uart_rx instance.
- It recognises the modem result lines "OK" and "ERROR", and the SMS text prompt "> ".
- It reports each result, or a timeout, to the alert sequencing logic while a command is outstanding. This lets message transmission be gated on modem acknowledgement.

Parameters:
- CLK_FREQ, 25_000_000: clk frequency in Hz.
- TIMEOUT_MS, 5000: response timeout in ms. TIMEOUT_CYCLES = (CLK_FREQ/1000)*TIMEOUT_MS; the counter width is sized from this value.
- MAX_LINE, 32: maximum characters held per line before overflow.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte from uart_rx.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
- arm  input  1  one-cycle pulse: a command was just sent, start waiting for its response.
- waiting  output  1  level: a command is outstanding.
- resp_ok  output  1  one-cycle pulse: "OK" line received while waiting.
- resp_error  output  1  one-cycle pulse: "ERROR" line received while waiting.
- resp_prompt  output  1  one-cycle pulse: "> " prompt received while waiting.
- resp_timeout  output  1  one-cycle pulse: no result within TIMEOUT_CYCLES.
- resp_code  output  3  last reported result: 0 NONE, 1 OK, 2 ERROR, 3 PROMPT, 4 TIMEOUT; held until the next result.
- line_overflow  output  1  one-cycle pulse: line exceeded MAX_LINE characters.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0; resp_code=NONE.
  - Line state returns to start-of-line and the timeout counter clears.
  - Reset mid-line or mid-wait discards everything.
- Line assembly:
  - Only bytes with rx_valid=1 are consumed.
  - CR (0x0D) and LF (0x0A) are terminators. Any other byte is appended at position len, and len increments.
  - Matching is exact and case-sensitive, by byte position against "OK" (len 2) and "ERROR" (len 5).
- On a terminator:
  - A line equal to exactly "OK" gives an OK result; exactly "ERROR" gives an ERROR result.
  - Anything else is ignored, including empty lines from CRLF pairs, "OK " and unsolicited lines such as "+CMTI...".
  - len then returns to 0.
- Prompt:
  - '>' (0x3E) at position 0 followed by ' ' (0x20) at position 1 gives a PROMPT result immediately on the space byte; no terminator is required.
  - After a prompt, the line state returns to start-of-line.
- Overflow:
  - When a non-terminator byte arrives with len==MAX_LINE, it is dropped and line_overflow pulses. The pulse fires once per line.
  - Further bytes are dropped until the next terminator, and that terminated line is ignored.
- Result reporting:
  - A result is reported only if waiting=1.
  - Reporting means: the matching resp_* pulse, resp_code updated, and waiting cleared.
  - Results arriving with waiting=0 are discarded silently, with no pulse and no resp_code change.
- Latency: the resp_* pulse is registered and asserts in the cycle after the rx_valid cycle of the deciding byte.
- Timeout counter:
  - arm sets waiting=1 and clears the counter.
  - The counter increments each cycle while waiting.
  - If waiting is still 1 at TIMEOUT_CYCLES cycles after the arm cycle, resp_timeout pulses, resp_code becomes TIMEOUT and waiting clears.
- Simultaneous events:
  - A result and timeout expiry on the same cycle: the result wins and no timeout pulse occurs.
  - arm and a result on the same cycle: the result is reported for the prior command. waiting then stays 1 and the counter restarts.
  - arm while already waiting: the counter restarts; no pulse.
- Outputs: at most one of resp_ok, resp_error, resp_prompt and resp_timeout is high in any cycle.

Decomposition:
- Shared package gsm_resp_pkg holds:
  - resp_code constants RESP_NONE/OK/ERROR/PROMPT/TIMEOUT (3 bits);
  - ASCII constants CR, LF, GT, SP;
  - the match strings "OK" and "ERROR".
- One natural sub-module, gsm_resp_timer: the parameterised timeout counter, with inputs start, stop and enable and a one-cycle expired pulse. The line matcher and reporting FSM (IDLE/WAIT) stay in the parent.

Test Plan:
- Basic OK: arm, then bytes CR LF 'O' 'K' CR LF -> one resp_ok pulse in the cycle after the 'K'-following CR; resp_code=1; waiting=0; the trailing LF has no effect.
- Error versus non-match: arm, "ERROR\r\n" -> resp_error, resp_code=2. Then arm, "ERRORS\r\n" followed by "ok\r\n" -> no pulse, waiting stays 1.
- Prompt: arm, bytes 0x3E 0x20 -> resp_prompt one cycle after 0x20, resp_code=3. Also: unarmed "OK\r\n" -> no pulse and resp_code unchanged.
- Timeout: set CLK_FREQ=1000, TIMEOUT_MS=10 so TIMEOUT_CYCLES=10; arm at cycle 0 with no bytes -> resp_timeout at cycle 10, resp_code=4. Then arm, and at cycle 9 "OK\r\n" completes its CR such that the OK pulse coincides with expiry -> resp_ok only.
- Overflow: MAX_LINE=4; arm, "ABCDEFOK\r\n" -> line_overflow pulses once on 'E', no resp_ok. Then "OK\r\n" -> resp_ok.
- Reset mid-line: arm, 'O', then rst=1 for 1 cycle, then 'K' CR -> no pulse; waiting=0; resp_code=0.
